// File: rtl/timed_intersection_controller.sv
// -----------------------------------------------------------------------------
// timed_intersection_controller
//
// Round-robin traffic light controller for NUM_DIRS approach directions.
// Each direction is given GREEN, then YELLOW, then an ALL_RED gap, and then
// the next direction takes its turn. A pedestrian request is latched and
// served as a PED_WALK phase at the next ALL_RED exit. flash_mode puts every
// lamp into a yellow/off flashing pattern; a green that is running when the
// request arrives first finishes through a full yellow. enable=0 freezes the
// whole controller, but pedestrian requests are still latched.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   enable      1 = run, 0 = hold state, timer and outputs
//   flash_mode  request the flashing mode
//   ped_req     pedestrian button (level or pulse)
//   light       per-direction lamp code, dir d at [2d+1:2d]
//               (00 red, 01 green, 10 yellow, 11 off)
//   active_dir  direction that owns green, or owned it last
//   ped_walk    pedestrian walk indication
//   phase_done  one-cycle pulse on every state change
// -----------------------------------------------------------------------------
module timed_intersection_controller #(
  parameter int NUM_DIRS      = 2,
  parameter int CNT_W         = 8,
  parameter int GREEN_CYCLES  = 20,
  parameter int YELLOW_CYCLES = 4,
  parameter int ALLRED_CYCLES = 2,
  parameter int PED_CYCLES    = 10,
  parameter int FLASH_HALF    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        flash_mode,
  input  logic                        ped_req,
  output logic [2*NUM_DIRS-1:0]       light,
  output logic [$clog2(NUM_DIRS)-1:0] active_dir,
  output logic                        ped_walk,
  output logic                        phase_done
);

  localparam int DIR_W = $clog2(NUM_DIRS);

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_GREEN  = 2'b01;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;
  localparam logic [1:0] LAMP_OFF    = 2'b11;

  typedef enum logic [2:0] {
    S_ALL_RED  = 3'd0,
    S_GREEN    = 3'd1,
    S_YELLOW   = 3'd2,
    S_PED_WALK = 3'd3,
    S_FLASH    = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [DIR_W-1:0]     dir_q, dir_d;
  logic                 flash_ph_q, flash_ph_d;
  logic                 ped_pending_q, ped_pending_d;
  logic [2*NUM_DIRS-1:0] light_q, light_d;
  logic                 ped_walk_q, ped_walk_d;
  logic                 phase_done_q, phase_done_d;

  logic                 timer_zero;
  logic                 ped_clr;
  logic [DIR_W-1:0]     dir_next;

  assign timer_zero = (timer_q == '0);
  assign dir_next   = (dir_q == DIR_W'(NUM_DIRS - 1)) ? '0 : dir_q + DIR_W'(1);

  // ---------------------------------------------------------------------------
  // State register. Outputs are registered here too, computed from the next
  // state, so they change on the same edge as the state with no extra stage.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_ALL_RED;
      timer_q       <= CNT_W'(ALLRED_CYCLES - 1);
      dir_q         <= DIR_W'(NUM_DIRS - 1);
      flash_ph_q    <= 1'b0;
      ped_pending_q <= 1'b0;
      light_q       <= '0;
      ped_walk_q    <= 1'b0;
      phase_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      dir_q         <= dir_d;
      flash_ph_q    <= flash_ph_d;
      ped_pending_q <= ped_pending_d;
      light_q       <= light_d;
      ped_walk_q    <= ped_walk_d;
      phase_done_q  <= phase_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. In FLASH the timer counts the half-period of the
  // yellow/off pattern; flash_ph selects which level is shown.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    dir_d      = dir_q;
    flash_ph_d = flash_ph_q;
    ped_clr    = 1'b0;

    if (enable) begin
      case (state_q)
        S_ALL_RED: begin
          if (!timer_zero) begin
            timer_d = timer_q - CNT_W'(1);
          end else if (flash_mode) begin
            // Flash wins over a pending walk; the walk stays latched.
            state_d    = S_FLASH;
            timer_d    = CNT_W'(FLASH_HALF - 1);
            flash_ph_d = 1'b0;
          end else if (ped_pending_q) begin
            state_d = S_PED_WALK;
            timer_d = CNT_W'(PED_CYCLES - 1);
            ped_clr = 1'b1;
          end else begin
            state_d = S_GREEN;
            timer_d = CNT_W'(GREEN_CYCLES - 1);
            dir_d   = dir_next;
          end
        end
        S_GREEN: begin
          // A flash request truncates green but always passes through yellow.
          if (timer_zero || flash_mode) begin
            state_d = S_YELLOW;
            timer_d = CNT_W'(YELLOW_CYCLES - 1);
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        S_YELLOW, S_PED_WALK: begin
          if (timer_zero) begin
            state_d = S_ALL_RED;
            timer_d = CNT_W'(ALLRED_CYCLES - 1);
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        S_FLASH: begin
          if (!flash_mode) begin
            state_d = S_ALL_RED;
            timer_d = CNT_W'(ALLRED_CYCLES - 1);
          end else if (timer_zero) begin
            flash_ph_d = ~flash_ph_q;
            timer_d    = CNT_W'(FLASH_HALF - 1);
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = S_ALL_RED;
          timer_d = CNT_W'(ALLRED_CYCLES - 1);
        end
      endcase
    end

    // The request is latched even while frozen; a new press wins over the
    // clear on the edge that enters PED_WALK.
    ped_pending_d = ped_req | (ped_pending_q & ~ped_clr);
  end

  // ---------------------------------------------------------------------------
  // Output logic, from the next state so the registered outputs line up with
  // the state register.
  // ---------------------------------------------------------------------------
  always_comb begin
    light_d      = '0;
    ped_walk_d   = (state_d == S_PED_WALK);
    phase_done_d = (state_d != state_q);

    for (int d = 0; d < NUM_DIRS; d++) begin
      case (state_d)
        S_GREEN:  light_d[2*d +: 2] = (dir_d == DIR_W'(d)) ? LAMP_GREEN  : LAMP_RED;
        S_YELLOW: light_d[2*d +: 2] = (dir_d == DIR_W'(d)) ? LAMP_YELLOW : LAMP_RED;
        S_FLASH:  light_d[2*d +: 2] = flash_ph_d ? LAMP_OFF : LAMP_YELLOW;
        default:  light_d[2*d +: 2] = LAMP_RED;
      endcase
    end
  end

  assign light      = light_q;
  assign active_dir = dir_q;
  assign ped_walk   = ped_walk_q;
  assign phase_done = phase_done_q;

endmodule

// File: tb/tb_timed_intersection_controller.sv
// -----------------------------------------------------------------------------
// tb_timed_intersection_controller
//
// Directed bench for the intersection controller with NUM_DIRS=2, GREEN=4,
// YELLOW=2, ALLRED=1, PED=3, FLASH_HALF=2. The stimulus process drives the
// inputs on the falling edge and queues the outputs expected after the next
// rising edge; the monitor pops one entry per rising edge and compares.
// -----------------------------------------------------------------------------
module tb_timed_intersection_controller;

  typedef struct {
    logic [3:0] light;
    logic       ped_walk;
    logic       phase_done;
    logic       dir;
    int         test_id;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       flash_mode;
  logic       ped_req;
  logic [3:0] light;
  logic [0:0] active_dir;
  logic       ped_walk;
  logic       phase_done;

  // Staged input values, applied by cyc() on the falling edge.
  logic rst_s, en_s, fm_s, pr_s;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   test_id = 0;
  int   cyc_n   = 0;

  timed_intersection_controller #(
    .NUM_DIRS      (2),
    .CNT_W         (8),
    .GREEN_CYCLES  (4),
    .YELLOW_CYCLES (2),
    .ALLRED_CYCLES (1),
    .PED_CYCLES    (3),
    .FLASH_HALF    (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .flash_mode (flash_mode),
    .ped_req    (ped_req),
    .light      (light),
    .active_dir (active_dir),
    .ped_walk   (ped_walk),
    .phase_done (phase_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int t, input int c,
                       input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s test%0d cycle%0d got %0h expected %0h", name, t, c, act, req);
    end
  endtask

  // One clock of stimulus plus the outputs expected after the following edge.
  task automatic cyc(input logic [3:0] l, input logic pw, input logic pd, input logic d);
    exp_t e;
    @(negedge clk);
    reset      = rst_s;
    enable     = en_s;
    flash_mode = fm_s;
    ped_req    = pr_s;
    e.light      = l;
    e.ped_walk   = pw;
    e.phase_done = pd;
    e.dir        = d;
    e.test_id    = test_id;
    e.cyc        = cyc_n;
    exp_q.push_back(e);
    cyc_n++;
  endtask

  // n cycles of the same lamp pattern; only the first may carry phase_done.
  task automatic rep(input logic [3:0] l, input logic pw, input logic pd_first,
                     input logic d, input int n);
    for (int i = 0; i < n; i++) cyc(l, pw, (i == 0) ? pd_first : 1'b0, d);
  endtask

  // Monitor: one comparison set per rising edge while expectations are queued.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("light",      e.test_id, e.cyc, light,      e.light);
      check("ped_walk",   e.test_id, e.cyc, ped_walk,   e.ped_walk);
      check("phase_done", e.test_id, e.cyc, phase_done, e.phase_done);
      check("active_dir", e.test_id, e.cyc, active_dir, e.dir);
    end
  end

  initial begin
    reset = 1'b0; enable = 1'b1; flash_mode = 1'b0; ped_req = 1'b0;
    rst_s = 1'b0; en_s = 1'b1; fm_s = 1'b0; pr_s = 1'b0;

    // Test 1: reset, then a full rotation and wrap back to dir 0.
    test_id = 1;
    cyc(4'b0000, 0, 0, 1);
    rst_s = 1'b1;
    rep(4'b0001, 0, 1, 0, 4);
    rep(4'b0010, 0, 1, 0, 2);
    rep(4'b0000, 0, 1, 0, 1);
    rep(4'b0100, 0, 1, 1, 4);
    rep(4'b1000, 0, 1, 1, 2);
    rep(4'b0000, 0, 1, 1, 1);

    // Test 2: one-cycle ped_req during dir0 green.
    test_id = 2;
    cyc(4'b0001, 0, 1, 0);
    pr_s = 1'b1;
    cyc(4'b0001, 0, 0, 0);
    pr_s = 1'b0;
    rep(4'b0001, 0, 0, 0, 2);
    rep(4'b0010, 0, 1, 0, 2);
    rep(4'b0000, 0, 1, 0, 1);
    rep(4'b0000, 1, 1, 0, 3);
    rep(4'b0000, 0, 1, 0, 1);
    rep(4'b0100, 0, 1, 1, 4);
    rep(4'b1000, 0, 1, 1, 2);
    rep(4'b0000, 0, 1, 1, 1);

    // Test 3: flash request in green cycle 2, full yellow, flashing, release.
    test_id = 3;
    rep(4'b0001, 0, 1, 0, 2);
    fm_s = 1'b1;
    rep(4'b0010, 0, 1, 0, 2);
    rep(4'b0000, 0, 1, 0, 1);
    rep(4'b1010, 0, 1, 0, 2);
    rep(4'b1111, 0, 0, 0, 2);
    rep(4'b1010, 0, 0, 0, 1);
    fm_s = 1'b0;
    rep(4'b0000, 0, 1, 0, 1);

    // Test 4: freeze mid-green; green still gets four enabled cycles.
    test_id = 4;
    rep(4'b0100, 0, 1, 1, 2);
    en_s = 1'b0;
    rep(4'b0100, 0, 0, 1, 5);
    en_s = 1'b1;
    rep(4'b0100, 0, 0, 1, 2);
    pr_s = 1'b1;
    cyc(4'b1000, 0, 1, 1);
    pr_s = 1'b0;

    // Test 5: reset mid-yellow with a walk pending; the walk is discarded.
    test_id = 5;
    rst_s = 1'b0;
    cyc(4'b0000, 0, 0, 1);
    rst_s = 1'b1;
    rep(4'b0001, 0, 1, 0, 4);
    rep(4'b0010, 0, 1, 0, 2);
    rep(4'b0000, 0, 1, 0, 1);
    rep(4'b0100, 0, 1, 1, 4);

    // Test 6: ped_req held through a walk gives a second walk, then dir 0.
    test_id = 6;
    pr_s = 1'b1;
    rep(4'b1000, 0, 1, 1, 2);
    rep(4'b0000, 0, 1, 1, 1);
    rep(4'b0000, 1, 1, 1, 3);
    pr_s = 1'b0;
    rep(4'b0000, 0, 1, 1, 1);
    rep(4'b0000, 1, 1, 1, 3);
    rep(4'b0000, 0, 1, 1, 1);
    rep(4'b0001, 0, 1, 0, 2);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timed_intersection_controller.md
Name: timed_intersection_controller

Overview:
Parametrised multi-direction traffic light controller. It sequences N approach directions round-robin through GREEN, YELLOW and ALL_RED, with a programmable cycle count per phase. It adds a latched pedestrian-walk phase, a fault/night flashing mode and a run enable. It sits between the system tick/clock domain and the lamp driver outputs, and supersedes the fixed single-light RED/GREEN/YELLOW sequencer.

Parameters:
NUM_DIRS, 2, number of approach directions (legal range 2..4)
CNT_W, 8, phase timer width; every *_CYCLES value must be between 1 and 2^CNT_W
GREEN_CYCLES, 20, cycles a direction stays green
YELLOW_CYCLES, 4, cycles of yellow after green
ALLRED_CYCLES, 2, cycles all directions are red between phases
PED_CYCLES, 10, cycles of pedestrian walk
FLASH_HALF, 8, half-period of the flashing pattern, in cycles

Ports:
clk  input  1  clock; all logic is on the rising edge
reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk
enable  input  1  1 = run; 0 = freeze state, timer and outputs
flash_mode  input  1  request flashing mode
ped_req  input  1  pedestrian button; level or pulse, latched internally
light  output  2*NUM_DIRS  per-direction lamp code; dir d occupies bits [2d+1:2d]; 00=Red, 01=Green, 10=Yellow, 11=Off
active_dir  output  $clog2(NUM_DIRS)  direction currently owning or last owning green
ped_walk  output  1  pedestrian walk indication
phase_done  output  1  one-cycle pulse on every state transition

Behaviour:
- States: ALL_RED, GREEN, YELLOW, PED_WALK, FLASH. Down-counting timer; on entry to a state it loads <STATE>_CYCLES-1. A timed state transitions on the edge where timer==0 and enable==1, so it lasts exactly <STATE>_CYCLES enabled cycles.
- Reset (reset==0 at a clk edge, also mid-operation):
  - state=ALL_RED, timer=ALLRED_CYCLES-1
  - active_dir=NUM_DIRS-1, so the first green is dir 0
  - light all 00, ped_walk=0, phase_done=0, ped_pending=0, flash phase=0
- Outputs are registered and update on the same edge as the state change, with no extra latency stage.
- Transitions:
  - ALL_RED -> FLASH if flash_mode=1.
  - ALL_RED -> PED_WALK if ped_pending=1; clears ped_pending on entry.
  - ALL_RED -> GREEN otherwise, with active_dir = (active_dir+1) mod NUM_DIRS, wrapping from NUM_DIRS-1 to 0.
  - GREEN -> YELLOW at timer==0, or on the next enabled edge if flash_mode=1 (green is truncated; yellow is never skipped).
  - YELLOW -> ALL_RED at timer==0. Yellow always runs in full.
  - PED_WALK -> ALL_RED at timer==0. active_dir is unchanged, so rotation resumes with the next direction.
  - FLASH: stays while flash_mode=1. On the first enabled edge with flash_mode=0 -> ALL_RED with a full ALLRED_CYCLES count; active_dir is unchanged.
- Lights:
  - GREEN: active_dir shows 01, all other directions 00.
  - YELLOW: active_dir shows 10, all other directions 00.
  - ALL_RED and PED_WALK: all directions 00.
  - FLASH: all directions alternate 10 / 11. Each level holds FLASH_HALF cycles, starting with 10 on entry.
- ped_walk=1 only in PED_WALK.
- ped_pending is set by any cycle with ped_req=1, including during PED_WALK. That request is served at the next ALL_RED exit. Set and clear on the same edge: set wins.
- Simultaneous flash_mode and ped_pending at ALL_RED exit: FLASH wins; ped_pending is retained.
- enable=0: timer, state, flash counter and outputs hold; phase_done=0; ped_req is still latched.
- phase_done pulses for one cycle on the edge where the state changes, FLASH self-toggles excluded.
- Unreachable state encodings recover to ALL_RED on the next edge.

Test Plan:
Settings for all tests: NUM_DIRS=2, GREEN=4, YELLOW=2, ALLRED=1, PED=3, FLASH_HALF=2.
1. Release reset, enable=1 -> light sequence: 0000 x1, 0001 x4, 0010 x2, 0000 x1, 0100 x4, 1000 x2, 0000 x1, then 0001 again (wrap). phase_done pulses at each change.
2. ped_req pulse for 1 cycle during dir0 GREEN -> after dir0 yellow and all-red: ped_walk=1 for 3 cycles with light=0000, then 0000 x1, then 0100 (dir1 green).
3. flash_mode=1 on GREEN cycle 2 -> YELLOW next cycle for 2 cycles, then ALL_RED x1. Then light alternates 1010 x2 / 1111 x2. Drop flash_mode -> 0000 x1, then the next direction turns green.
4. enable=0 for 5 cycles mid-GREEN -> light and timer frozen; green resumes with its remaining count (4 total enabled cycles).
5. reset=0 for 1 cycle mid-YELLOW with ped_pending=1 -> next cycle light=0000, ped_pending=0, active_dir=1. Sequence restarts per test 1.
6. ped_req held high through PED_WALK -> a second PED_WALK occurs after the following ALL_RED, and vehicle rotation is preserved.
